// File: rtl/axis_byte_packer.sv
`default_nettype none
// ============================================================================
// axis_byte_packer : packs an 8-bit AXI4-Stream into DATA_BYTES-wide words,
//                    LSB first, with flush-driven partial words (TKEEP/TLAST).
// Revision 1.0
// ============================================================================
module axis_byte_packer #(
    parameter int DATA_BYTES = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [7:0]              s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    flush,
    output logic [8*DATA_BYTES-1:0] m_axis_tdata,
    output logic [DATA_BYTES-1:0]   m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
);

    localparam int CNT_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int N_W   = CNT_W + 1;
    localparam int DW    = 8 * DATA_BYTES;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BYTES - 1);

    if ((DATA_BYTES < 2) || (DATA_BYTES > 16)) begin : g_param_check
        $error("axis_byte_packer: DATA_BYTES must be within 2..16");
    end

    logic [DW-1:0]         acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  fp_q, fp_d;
    logic                  rdy_q;
    logic [DW-1:0]         tdata_q, tdata_d;
    logic [DATA_BYTES-1:0] tkeep_q, tkeep_d;
    logic                  tlast_q, tlast_d;
    logic                  tvalid_q, tvalid_d;

    logic                  w_accept;
    logic                  w_drain;
    logic                  w_slot_free;
    logic [DW-1:0]         w_acc_ins;
    logic [N_W-1:0]        w_n;
    logic [DATA_BYTES-1:0] w_keep_part;
    logic [DW-1:0]         w_data_part;

    // Ready depends only on registers so upstream never sees a path from flush or m_axis_tready.
    assign s_axis_tready = rdy_q & ~fp_q & ~((cnt_q == LAST_IDX) & tvalid_q);

    assign w_accept    = s_axis_tvalid & s_axis_tready;
    assign w_drain     = tvalid_q & m_axis_tready;
    assign w_slot_free = ~tvalid_q | m_axis_tready;
    assign w_n         = {1'b0, cnt_q} + N_W'(w_accept);

    always_comb begin
        w_acc_ins = acc_q;
        if (w_accept) begin
            w_acc_ins[8*cnt_q +: 8] = s_axis_tdata;
        end
        w_keep_part = '0;
        w_data_part = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            w_keep_part[k] = (N_W'(k) < w_n);
            if (w_keep_part[k]) begin
                w_data_part[8*k +: 8] = w_acc_ins[8*k +: 8];
            end
        end
    end

    always_comb begin
        acc_d    = w_acc_ins;
        cnt_d    = cnt_q;
        fp_d     = fp_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q & ~w_drain;

        if (fp_q) begin
            // No byte can be accepted while pending, so w_n equals cnt_q here.
            if (w_slot_free) begin
                tdata_d  = w_data_part;
                tkeep_d  = w_keep_part;
                tlast_d  = 1'b1;
                tvalid_d = 1'b1;
                cnt_d    = '0;
                fp_d     = 1'b0;
            end
        end else if (w_accept && (cnt_q == LAST_IDX)) begin
            tdata_d  = w_acc_ins;
            tkeep_d  = '1;
            tlast_d  = flush;
            tvalid_d = 1'b1;
            cnt_d    = '0;
        end else if (flush && (w_n != '0)) begin
            if (w_slot_free) begin
                tdata_d  = w_data_part;
                tkeep_d  = w_keep_part;
                tlast_d  = 1'b1;
                tvalid_d = 1'b1;
                cnt_d    = '0;
            end else begin
                fp_d  = 1'b1;
                cnt_d = w_n[CNT_W-1:0];
            end
        end else if (w_accept) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            fp_q     <= 1'b0;
            rdy_q    <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            fp_q     <= fp_d;
            rdy_q    <= 1'b1;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_byte_packer.sv
`default_nettype none
// ============================================================================
// tb_axis_byte_packer : directed scoreboard bench for axis_byte_packer (4 bytes)
// Revision 1.0
// ============================================================================
module tb_axis_byte_packer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        flush;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    word_t      sb[$];
    logic [7:0] mbuf[4];
    int         mcnt = 0;
    int         checks = 0;
    int         errors = 0;

    logic        stall_seen = 1'b0;
    logic [36:0] stall_val  = '0;

    always #5 aclk = ~aclk;

    axis_byte_packer #(.DATA_BYTES(4)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .flush         (flush),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_emit(input logic fl);
        word_t w;
        w = '0;
        for (int i = 0; i < mcnt; i++) begin
            w.d[8*i +: 8] = mbuf[i];
            w.k[i]        = 1'b1;
        end
        w.l = fl;
        sb.push_back(w);
        mcnt = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic fl);
        mbuf[mcnt] = b;
        mcnt++;
        if (mcnt == 4 || fl) model_emit(fl);
    endtask

    task automatic model_flush();
        if (mcnt > 0) model_emit(1'b1);
    endtask

    task automatic cycle();
        @(posedge aclk);
        #1;
    endtask

    // Offers one byte (optionally with flush in the accepting cycle) until it is taken.
    task automatic send_byte(input logic [7:0] b, input logic fl);
        bit done = 0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (s_tready) begin
                flush = fl;
                model_byte(b, fl);
                done = 1;
            end
            cycle();
        end
        s_tvalid = 1'b0;
        flush    = 1'b0;
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic flush_only();
        flush = 1'b1;
        model_flush();
        cycle();
        flush = 1'b0;
    endtask

    task automatic drain_wait();
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (sb.size() == 0 && !m_tvalid) done = 1;
            else cycle();
        end
        if (!done) check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge aclk) begin
        if (aresetn && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", {27'd0, m_tdata, m_tkeep, m_tlast}, 64'd0);
            end else begin
                word_t e;
                e = sb.pop_front();
                check("word_data", 64'(m_tdata), 64'(e.d));
                check("word_keep", 64'(m_tkeep), 64'(e.k));
                check("word_last", 64'(m_tlast), 64'(e.l));
            end
        end
        if (aresetn && m_tvalid && !m_tready) begin
            if (stall_seen) check("hold_stable", 64'({m_tdata, m_tkeep, m_tlast}), 64'(stall_val));
            stall_seen = 1'b1;
            stall_val  = {m_tdata, m_tkeep, m_tlast};
        end else begin
            stall_seen = 1'b0;
        end
    end

    initial begin
        aresetn  = 1'b0;
        s_tdata  = 8'h00;
        s_tvalid = 1'b0;
        flush    = 1'b0;
        m_tready = 1'b1;

        #3;
        check("rst_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_tdata",  64'(m_tdata),  64'd0);
        check("rst_tkeep",  64'(m_tkeep),  64'd0);
        check("rst_tlast",  64'(m_tlast),  64'd0);
        check("rst_sready", 64'(s_tready), 64'd0);
        #19 aresetn = 1'b1;
        cycle();
        check("sready_after_rst", 64'(s_tready), 64'd1);

        // Full words back to back.
        for (int i = 1; i <= 8; i++) begin
            check("sready_stream", 64'(s_tready), 64'd1);
            send_byte(8'(i), 1'b0);
            if (i == 4) begin
                check("w0_latency_valid", 64'(m_tvalid), 64'd1);
                check("w0_data", 64'(m_tdata), 64'h04030201);
            end
            if (i == 8) begin
                check("w1_latency_valid", 64'(m_tvalid), 64'd1);
                check("w1_data", 64'(m_tdata), 64'h08070605);
            end
        end
        drain_wait();

        // Partial word via a lone flush, then a normal word.
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        flush_only();
        check("partial_valid", 64'(m_tvalid), 64'd1);
        check("partial_keep",  64'(m_tkeep),  64'h3);
        for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 1'b0);
        drain_wait();

        // Backpressure: two words with the sink stalled.
        m_tready = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(8'h10 + 8'(i), 1'b0);
        check("sready_drop_7th", 64'(s_tready), 64'd0);
        m_tready = 1'b1;
        send_byte(8'h17, 1'b0);
        drain_wait();

        // Flush while the output slot is occupied.
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i), 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h31, 1'b0);
        flush_only();
        check("sready_fp", 64'(s_tready), 64'd0);
        repeat (2) cycle();
        check("sready_fp_hold", 64'(s_tready), 64'd0);
        m_tready = 1'b1;
        drain_wait();
        check("sready_after_fp", 64'(s_tready), 64'd1);

        // Flush coincident with the completing byte, then an empty flush.
        for (int i = 0; i < 3; i++) send_byte(8'h40 + 8'(i), 1'b0);
        send_byte(8'h43, 1'b1);
        check("coinc_keep", 64'(m_tkeep), 64'hF);
        check("coinc_last", 64'(m_tlast), 64'd1);
        drain_wait();
        flush_only();
        repeat (3) cycle();
        check("empty_flush_novalid", 64'(m_tvalid), 64'd0);

        // Reset with a held word and a partial accumulation.
        m_tready = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(8'h50 + 8'(i), 1'b0);
        #1 aresetn = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        check("mid_rst_tdata",  64'(m_tdata),  64'd0);
        check("mid_rst_tkeep",  64'(m_tkeep),  64'd0);
        check("mid_rst_sready", 64'(s_tready), 64'd0);
        sb.delete();
        mcnt = 0;
        @(negedge aclk);
        #1 aresetn = 1'b1;
        cycle();
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'h91 + 8'(i), 1'b0);
        check("post_rst_data", 64'(m_tdata), 64'h94939291);
        drain_wait();
        check("final_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
